fifo_syn: RTL and testbench

Single-clock parametrised FIFO, the same-clock-domain successor to the team's asynchronous FIFO. It adds a selectable read mode (standard or first-word-fall-through), programmable almost-full/almost-empty thresholds, an occupancy count and optional sticky error flags. It sits between producer/consumer pipelines that share one clock, where gray-pointer crossing is unnecessary overhead. Storage is an internal register/RAM array with a registered read.

---
 rtl/fifo_syn_if.sv | 33 +++
 rtl/fifo_syn.sv | 144 ++++++++++++++
 tb/tb_fifo_syn.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_syn_if.sv
// fifo_syn_if: write/read handshake bundle for the single-clock FIFO.
// master = producer/consumer side, slave = FIFO side.
interface fifo_syn_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_data, wr_en, rd_en,
        input  full, almost_full, rd_data, rd_valid,
        input  empty, almost_empty, data_count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output full, almost_full, rd_data, rd_valid,
        output empty, almost_empty, data_count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_syn.sv
// fifo_syn: single-clock FIFO, std or fwft read, thresholds, count.
// Ports: clk, rst (sync, active high), bus (fifo_syn_if.slave).
// Macro FIFO_SYN_ERR_FLAG_EN enables sticky overflow/underflow.
module fifo_syn #(
    parameter int    DATA_WIDTH = 36,
    parameter int    ADDR_WIDTH = 4,
    parameter string READ_MODE  = "std",
    parameter int    AF_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int    AE_THRESH  = 1,
    parameter string RAM_TYPE   = "distributed"
) (
    input logic       clk,
    input logic       rst,
    fifo_syn_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit FWFT  = (READ_MODE == "fwft");

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (READ_MODE != "std" && READ_MODE != "fwft") begin : g_bad_mode
        $error("fifo_syn: READ_MODE must be std or fwft");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_syn: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_syn: AE_THRESH out of range 0..DEPTH-1");
    end
    if (RAM_TYPE != "block" && RAM_TYPE != "distributed"
        && RAM_TYPE != "registers") begin : g_bad_ram
        $error("fifo_syn: RAM_TYPE must be block/distributed/registers");
    end

    (* ram_style = RAM_TYPE *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   mem_words;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full, empty;
    logic                  wr_acc, rd_acc, load;

    assign full  = (count_q == DEPTH_C);
    assign empty = FWFT ? !rd_valid_q : (count_q == '0);

    // In fwft, !empty is rd_valid, so one expression covers both modes.
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    // Words in the array that are not yet in the output register.
    assign mem_words = count_q - {{ADDR_WIDTH{1'b0}}, rd_valid_q};

    // std loads on every accepted read; fwft refills the output
    // register when it is free or being popped.
    assign load = FWFT
        ? ((!rd_valid_q || rd_acc) && (mem_words != '0))
        : rd_acc;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        count_d    = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (load) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = mem_q[rd_ptr_q];
        end
        if (FWFT) begin
            rd_valid_d = load || (rd_valid_q && !rd_acc);
        end else begin
            rd_valid_d = rd_acc;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.data_count   = count_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;

`ifdef FIFO_SYN_ERR_FLAG_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr_en && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_syn.sv
// tb_fifo_syn: std and fwft FIFOs (depth 4) driven with the same
// directed vectors, checked against queue models and literals.
module tb_fifo_syn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_syn_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) s_if ();
    fifo_syn_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f_if ();

    fifo_syn #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .READ_MODE("std"),
        .AF_THRESH(3), .AE_THRESH(1), .RAM_TYPE("distributed")
    ) u_std (.clk(clk), .rst(rst), .bus(s_if.slave));

    fifo_syn #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .READ_MODE("fwft"),
        .AF_THRESH(3), .AE_THRESH(1), .RAM_TYPE("registers")
    ) u_fwft (.clk(clk), .rst(rst), .bus(f_if.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // std model: queue of stored words plus output register
    logic [7:0] sq[$];
    logic       s_rdv = 1'b0;
    logic [7:0] s_rdd = 8'h00;
    logic       s_ovf = 1'b0;
    logic       s_unf = 1'b0;
    // fwft model: queue of all words; head is shown when f_pv
    logic [7:0] fq[$];
    logic       f_pv  = 1'b0;
    logic [7:0] f_rdd = 8'h00;
    logic       f_ovf = 1'b0;
    logic       f_unf = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("std.count", int'(s_if.data_count), sq.size());
            chk("std.full", int'(s_if.full), int'(sq.size() == 4));
            chk("std.empty", int'(s_if.empty), int'(sq.size() == 0));
            chk("std.afull", int'(s_if.almost_full), int'(sq.size() >= 3));
            chk("std.aempty", int'(s_if.almost_empty), int'(sq.size() <= 1));
            chk("std.rd_valid", int'(s_if.rd_valid), int'(s_rdv));
            chk("std.rd_data", int'(s_if.rd_data), int'(s_rdd));
            chk("std.overflow", int'(s_if.overflow), int'(s_ovf));
            chk("std.underflow", int'(s_if.underflow), int'(s_unf));
            chk("fwft.count", int'(f_if.data_count), fq.size());
            chk("fwft.full", int'(f_if.full), int'(fq.size() == 4));
            chk("fwft.empty", int'(f_if.empty), int'(!f_pv));
            chk("fwft.afull", int'(f_if.almost_full), int'(fq.size() >= 3));
            chk("fwft.aempty", int'(f_if.almost_empty), int'(fq.size() <= 1));
            chk("fwft.rd_valid", int'(f_if.rd_valid), int'(f_pv));
            chk("fwft.rd_data", int'(f_if.rd_data), int'(f_rdd));
            chk("fwft.overflow", int'(f_if.overflow), int'(f_ovf));
            chk("fwft.underflow", int'(f_if.underflow), int'(f_unf));
        end
    end

    task automatic model(input logic r, input logic we,
                         input logic [7:0] wd, input logic re);
        int  n;
        int  inmem;
        bit  wa, ra, ld;
        if (r) begin
            sq.delete();
            s_rdv = 1'b0; s_rdd = 8'h00; s_ovf = 1'b0; s_unf = 1'b0;
            fq.delete();
            f_pv = 1'b0; f_rdd = 8'h00; f_ovf = 1'b0; f_unf = 1'b0;
            return;
        end
        n  = sq.size();
        wa = we && (n < 4);
        ra = re && (n > 0);
`ifdef FIFO_SYN_ERR_FLAG_EN
        if (we && n == 4) s_ovf = 1'b1;
        if (re && n == 0) s_unf = 1'b1;
`endif
        s_rdv = ra;
        if (ra) s_rdd = sq.pop_front();
        if (wa) sq.push_back(wd);

        n     = fq.size();
        wa    = we && (n < 4);
        ra    = re && f_pv;
        inmem = n - int'(f_pv);
        ld    = (!f_pv || ra) && (inmem > 0);
`ifdef FIFO_SYN_ERR_FLAG_EN
        if (we && n == 4) f_ovf = 1'b1;
        if (re && !f_pv) f_unf = 1'b1;
`endif
        if (ra) void'(fq.pop_front());
        if (ld) begin
            f_pv  = 1'b1;
            f_rdd = fq[0];
        end else if (ra) begin
            f_pv = 1'b0;
        end
        if (wa) fq.push_back(wd);
    endtask

    task automatic step(input logic r, input logic we,
                        input logic [7:0] wd, input logic re);
        rst = r;
        s_if.wr_en = we; s_if.wr_data = wd; s_if.rd_en = re;
        f_if.wr_en = we; f_if.wr_data = wd; f_if.rd_en = re;
        @(posedge clk);
        model(r, we, wd, re);
        @(negedge clk);
    endtask

    int seq[10];

    initial begin
        s_if.wr_en = 1'b0; s_if.wr_data = 8'h00; s_if.rd_en = 1'b0;
        f_if.wr_en = 1'b0; f_if.wr_data = 8'h00; f_if.rd_en = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("lit.rst_std_empty", int'(s_if.empty), 1);
        chk("lit.rst_std_ae", int'(s_if.almost_empty), 1);
        chk("lit.rst_std_cnt", int'(s_if.data_count), 0);
        chk("lit.rst_std_rdd", int'(s_if.rd_data), 0);
        chk("lit.rst_fwft_empty", int'(f_if.empty), 1);
        chk("lit.rst_fwft_rdv", int'(f_if.rd_valid), 0);

        // fill 1..4, thresholds AF=3 AE=1
        step(1'b0, 1'b1, 8'h01, 1'b0);
        chk("lit.std_ae_c1", int'(s_if.almost_empty), 1);
        chk("lit.fwft_rdv_n", int'(f_if.rd_valid), 0);
        step(1'b0, 1'b1, 8'h02, 1'b0);
        chk("lit.std_ae_c2", int'(s_if.almost_empty), 0);
        chk("lit.std_af_c2", int'(s_if.almost_full), 0);
        chk("lit.fwft_rdv_n1", int'(f_if.rd_valid), 1);
        chk("lit.fwft_rdd_n1", int'(f_if.rd_data), 1);
        step(1'b0, 1'b1, 8'h03, 1'b0);
        chk("lit.std_af_c3", int'(s_if.almost_full), 1);
        step(1'b0, 1'b1, 8'h04, 1'b0);
        chk("lit.std_full", int'(s_if.full), 1);
        chk("lit.std_cnt4", int'(s_if.data_count), 4);
        chk("lit.fwft_cnt4", int'(f_if.data_count), 4);

        // full with simultaneous write/read: write dropped
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("lit.std_cnt3", int'(s_if.data_count), 3);
        chk("lit.std_rd1", int'(s_if.rd_data), 1);
        chk("lit.fwft_cnt3", int'(f_if.data_count), 3);
        chk("lit.fwft_rd2", int'(f_if.rd_data), 2);
        for (int k = 2; k <= 4; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("lit.std_rdk", int'(s_if.rd_data), k);
            chk("lit.std_rdvk", int'(s_if.rd_valid), 1);
        end
        chk("lit.std_empty", int'(s_if.empty), 1);
        chk("lit.fwft_empty", int'(f_if.empty), 1);

        // read while empty is ignored
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("lit.std_rdv_ign", int'(s_if.rd_valid), 0);

        // fwft single word latency
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("lit.fwft_a5_n", int'(f_if.rd_valid), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("lit.fwft_a5_rdv", int'(f_if.rd_valid), 1);
        chk("lit.fwft_a5_rdd", int'(f_if.rd_data), 'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("lit.fwft_a5_pop", int'(f_if.empty), 1);
        chk("lit.std_a5", int'(s_if.rd_data), 'hA5);

        // half full, write+read for 8 cycles across pointer wrap
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        seq = '{'h10, 'h11, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h20 + 8'(i), 1'b1);
            chk("lit.thru_std_cnt", int'(s_if.data_count), 2);
            chk("lit.thru_std_rd", int'(s_if.rd_data), seq[i]);
            chk("lit.thru_fwft_cnt", int'(f_if.data_count), 2);
            chk("lit.thru_fwft_rd", int'(f_if.rd_data), seq[i+1]);
        end

        // reset with 3 words held
        step(1'b0, 1'b1, 8'h30, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("lit.mrst_std_empty", int'(s_if.empty), 1);
        chk("lit.mrst_std_cnt", int'(s_if.data_count), 0);
        chk("lit.mrst_fwft_rdv", int'(f_if.rd_valid), 0);
        chk("lit.mrst_ovf", int'(s_if.overflow), 0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("lit.new_fwft", int'(f_if.rd_data), 'h77);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("lit.new_std", int'(s_if.rd_data), 'h77);
        chk("lit.new_std_empty", int'(s_if.empty), 1);

        // mixed traffic, model-checked
        for (int i = 0; i < 60; i++) begin
            step(i == 30, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
